// File: rtl/vga_timing_if.sv
// Video timing bundle without colour: pixel/line counters plus blank and sync strobes.
interface itf_vga_no_rgb;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk
  );

  modport slave (
    input hcount, hsync, hblnk, vcount, vsync, vblnk
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running 1024x768@60 timing generator: counters, blank/sync strobes and a frame-start pulse.
module vga_timing #(
  parameter logic [10:0] H_TOTAL   = 11'd1343,
  parameter logic [10:0] H_B_START = 11'd1023,
  parameter logic [10:0] H_B_END   = 11'd1343,
  parameter logic [10:0] H_S_START = 11'd1047,
  parameter logic [10:0] H_S_END   = 11'd1183,
  parameter logic [10:0] V_TOTAL   = 11'd805,
  parameter logic [10:0] V_B_START = 11'd768,
  parameter logic [10:0] V_B_END   = 11'd806,
  parameter logic [10:0] V_S_START = 11'd771,
  parameter logic [10:0] V_S_END   = 11'd777
) (
  input  logic                 clk,
  input  logic                 rst,
  itf_vga_no_rgb.master        out,
  output logic                 new_frame
);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;
  logic        new_frame_q, new_frame_d;
  logic        h_wrap;
  logic        v_wrap;

  // Strobes are decoded from the next counter values so they land on the
  // same edge as the counters they describe.
  always_comb begin
    h_wrap      = (hcount_q == H_TOTAL);
    v_wrap      = (vcount_q == V_TOTAL);
    hcount_d    = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d    = vcount_q;
    if (h_wrap) begin
      vcount_d  = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d     = (hcount_d > H_B_START) && (hcount_d <= H_B_END);
    hsync_d     = (hcount_d > H_S_START) && (hcount_d <= H_S_END);
    vblnk_d     = (vcount_d >= V_B_START) && (vcount_d <= V_B_END - 11'd1);
    vsync_d     = (vcount_d >= V_S_START) && (vcount_d <= V_S_END - 11'd1);
    new_frame_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      hsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vsync_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync_q     <= hsync_d;
      hblnk_q     <= hblnk_d;
      vsync_q     <= vsync_d;
      vblnk_q     <= vblnk_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vsync  = vsync_q;
  assign out.vblnk  = vblnk_q;
  assign new_frame  = new_frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, shrunken instance for whole frames.
module tb_vga_timing;

  // {H_TOTAL, H_B_START, H_B_END, H_S_START, H_S_END, V_TOTAL, V_B_START, V_B_END, V_S_START, V_S_END}
  localparam int PB[10] = '{1343, 1023, 1343, 1047, 1183, 805, 768, 806, 771, 777};
  localparam int PS[10] = '{39, 29, 39, 31, 35, 19, 15, 20, 16, 18};
  localparam int SMALL_FRAME = (39 + 1) * (19 + 1);

  logic clk = 1'b0;
  logic rst_big;
  logic rst_small;
  logic nf_big;
  logic nf_small;

  itf_vga_no_rgb if_big ();
  itf_vga_no_rgb if_small ();

  vga_timing u_big (
    .clk       (clk),
    .rst       (rst_big),
    .out       (if_big),
    .new_frame (nf_big)
  );

  vga_timing #(
    .H_TOTAL   (11'd39),
    .H_B_START (11'd29),
    .H_B_END   (11'd39),
    .H_S_START (11'd31),
    .H_S_END   (11'd35),
    .V_TOTAL   (11'd19),
    .V_B_START (11'd15),
    .V_B_END   (11'd20),
    .V_S_START (11'd16),
    .V_S_END   (11'd18)
  ) u_small (
    .clk       (clk),
    .rst       (rst_small),
    .out       (if_small),
    .new_frame (nf_small)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int t_big = 0;
  int t_small = 0;
  int pulses_small = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs come straight from elapsed clocks since reset release.
  task automatic model_chk(input string tag, input int p[10], input int t,
                           input logic [10:0] hc, input logic [10:0] vc,
                           input logic hs, input logic hb, input logic vs,
                           input logic vb, input logic nf);
    int l, f, eh, ev;
    l  = p[0] + 1;
    f  = l * (p[5] + 1);
    eh = t % l;
    ev = (t / l) % (p[5] + 1);
    chk($sformatf("%s.hcount@t%0d", tag, t), 32'(hc), eh);
    chk($sformatf("%s.vcount@t%0d", tag, t), 32'(vc), ev);
    chk($sformatf("%s.hblnk@t%0d", tag, t), 32'(hb), (eh > p[1] && eh <= p[2]) ? 1 : 0);
    chk($sformatf("%s.hsync@t%0d", tag, t), 32'(hs), (eh > p[3] && eh <= p[4]) ? 1 : 0);
    chk($sformatf("%s.vblnk@t%0d", tag, t), 32'(vb), (ev >= p[6] && ev <= p[7] - 1) ? 1 : 0);
    chk($sformatf("%s.vsync@t%0d", tag, t), 32'(vs), (ev >= p[8] && ev <= p[9] - 1) ? 1 : 0);
    chk($sformatf("%s.new_frame@t%0d", tag, t), 32'(nf), (t != 0 && t % f == 0) ? 1 : 0);
    chk($sformatf("%s.bounds@t%0d", tag, t),
        (32'(hc) <= p[0] && 32'(vc) <= p[5]) ? 1 : 0, 1);
  endtask

  task automatic step();
    logic rb, rs;
    rb = rst_big;
    rs = rst_small;
    @(posedge clk);
    #1;
    t_big   = rb ? 0 : t_big + 1;
    t_small = rs ? 0 : t_small + 1;
    if (nf_small === 1'b1) pulses_small++;
    model_chk("big", PB, t_big, if_big.hcount, if_big.vcount, if_big.hsync,
              if_big.hblnk, if_big.vsync, if_big.vblnk, nf_big);
    model_chk("small", PS, t_small, if_small.hcount, if_small.vcount, if_small.hsync,
              if_small.hblnk, if_small.vsync, if_small.vblnk, nf_small);
  endtask

  initial begin
    int n;
    int idle;
    bit found;

    // Reset held for two cycles.
    rst_big   = 1'b1;
    rst_small = 1'b1;
    step();
    step();
    chk("reset.hcount", 32'(if_big.hcount), 0);
    chk("reset.vcount", 32'(if_big.vcount), 0);
    chk("reset.strobes", {28'd0, if_big.hsync, if_big.hblnk, if_big.vsync, if_big.vblnk}, 0);
    chk("reset.new_frame", 32'(nf_big), 0);

    // Release: hcount counts 1,2,3.
    rst_big   = 1'b0;
    rst_small = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("release.hcount%0d", i), 32'(if_big.hcount), i);
    end

    // Several full-size lines and several small frames.
    repeat (4100) step();
    chk("small.pulse_count", pulses_small, t_small / SMALL_FRAME);
    chk("big.vcount_after_lines", 32'(if_big.vcount), t_big / 1344);

    // Mid-frame reset on the small instance.
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      if (if_small.vcount == 11'd10 && if_small.hcount == 11'd20) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("small.midframe_reached", 32'(found), 1);
    rst_small = 1'b1;
    step();
    chk("small.midreset.hcount", 32'(if_small.hcount), 0);
    chk("small.midreset.vcount", 32'(if_small.vcount), 0);
    chk("small.midreset.new_frame", 32'(nf_small), 0);
    rst_small = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 4 * SMALL_FRAME) begin
      step();
      n++;
      if (nf_small === 1'b1) found = 1'b1;
    end
    chk("small.first_frame_delay", n, SMALL_FRAME);

    // Mid-line reset on the full-size instance, then one more line.
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      if (if_big.hcount == 11'd700 && if_big.vcount != 11'd0) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("big.midframe_reached", 32'(found), 1);
    rst_big = 1'b1;
    step();
    chk("big.midreset.hcount", 32'(if_big.hcount), 0);
    chk("big.midreset.vcount", 32'(if_big.vcount), 0);
    chk("big.midreset.strobes", {28'd0, if_big.hsync, if_big.hblnk, if_big.vsync, if_big.vblnk}, 0);
    rst_big = 1'b0;
    repeat (1400) step();
    chk("big.line_after_reset", 32'(if_big.vcount), 1);

    // Random idle in reset, then three full small frames.
    rst_small = 1'b1;
    idle = int'($urandom_range(1, 37));
    repeat (idle) step();
    rst_small = 1'b0;
    pulses_small = 0;
    repeat (3 * SMALL_FRAME + 7) step();
    chk("small.three_frames", pulses_small, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
